// File: rtl/sram_array_seq.sv
// Access sequencer for a ROWS x COLS mixed-signal SRAM array: turns a
// request/response handshake into timed precharge, wordline, write-driver and sense pulses.
module sram_array_seq #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WR_CYC  = 3,
  parameter int RD_CYC  = 3,
  parameter int SA_CYC  = 1,
  localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              precharge,
  output logic [ROWS-1:0]   wl_wr,
  output logic [ROWS-1:0]   wl_rd,
  output logic              wr_en,
  output logic [COLS-1:0]   din,
  output logic              sae,
  input  logic [COLS-1:0]   sa_out
);

  localparam int MAX_AB  = (PRE_CYC > WR_CYC) ? PRE_CYC : WR_CYC;
  localparam int MAX_CD  = (RD_CYC > SA_CYC) ? RD_CYC : SA_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W+1)'(ROWS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RDWL  = 3'd3;
  localparam logic [2:0] ST_SENSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COLS-1:0]   wdata_q;
  logic              err_q;
  logic              addr_ok;
  logic              err_nxt;
  logic              accept;
  logic [ROWS-1:0]   row_sel;

  assign addr_ok = ({1'b0, req_addr} < ROWS_L);
  assign accept  = (state == ST_IDLE) && req_valid;
  assign err_nxt = (state == ST_IDLE) ? !addr_ok : err_q;

  // Row decode of the latched address; out-of-range addresses select nothing.
  always_comb begin
    row_sel = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_sel[i] = (addr_q == ADDR_W'(i));
    end
  end

  // Next-state and phase counter; the counter reloads on every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (addr_ok) begin
            state_nxt = ST_PRE;
            cnt_nxt   = CNT_W'(PRE_CYC - 1);
          end else begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (cnt == '0) begin
          if (we_q) begin
            state_nxt = ST_WRITE;
            cnt_nxt   = CNT_W'(WR_CYC - 1);
          end else begin
            state_nxt = ST_RDWL;
            cnt_nxt   = CNT_W'(RD_CYC - 1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RDWL: begin
        if (cnt == '0) begin
          state_nxt = ST_SENSE;
          cnt_nxt   = CNT_W'(SA_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SENSE: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= !addr_ok;
      end
    end
  end

  // Outputs are registered from the next state, so every pulse is glitch-free
  // and precharge falls on the same edge that raises the wordline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      precharge <= 1'b0;
      wl_wr     <= '0;
      wl_rd     <= '0;
      wr_en     <= 1'b0;
      din       <= '0;
      sae       <= 1'b0;
    end else begin
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_DONE);
      rsp_err   <= (state_nxt == ST_DONE) && err_nxt;
      rsp_rdata <= ((state == ST_SENSE) && (state_nxt == ST_DONE)) ? sa_out : '0;
      precharge <= (state_nxt == ST_PRE);
      wl_wr     <= (state_nxt == ST_WRITE) ? row_sel : '0;
      wl_rd     <= ((state_nxt == ST_RDWL) || (state_nxt == ST_SENSE)) ? row_sel : '0;
      wr_en     <= (state_nxt == ST_WRITE);
      din       <= (state_nxt == ST_WRITE) ? wdata_q : '0;
      sae       <= (state_nxt == ST_SENSE);
    end
  end

endmodule

// File: tb/tb_sram_array_seq.sv
// Directed bench for sram_array_seq: a default build and a ROWS=3 fast-timing build.
module tb_sram_array_seq;

  localparam int ROWS_C [2] = '{4, 3};
  localparam int PRE_C  [2] = '{2, 1};
  localparam int WR_C   [2] = '{3, 1};
  localparam int RD_C   [2] = '{3, 1};
  localparam int SA_C   [2] = '{1, 2};

  logic clk;
  logic rst;

  logic       req_valid [2];
  logic       req_we    [2];
  logic [1:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] sa_out    [2];

  logic       req_ready [2];
  logic       rsp_valid [2];
  logic       rsp_err   [2];
  logic [7:0] rsp_rdata [2];
  logic       precharge [2];
  logic [3:0] wl_wr     [2];
  logic [3:0] wl_rd     [2];
  logic       wr_en     [2];
  logic [7:0] din       [2];
  logic       sae       [2];

  logic       req_ready_a, rsp_valid_a, rsp_err_a, precharge_a, wr_en_a, sae_a;
  logic [7:0] rsp_rdata_a, din_a;
  logic [3:0] wl_wr_a, wl_rd_a;
  logic       req_ready_b, rsp_valid_b, rsp_err_b, precharge_b, wr_en_b, sae_b;
  logic [7:0] rsp_rdata_b, din_b;
  logic [2:0] wl_wr_b, wl_rd_b;

  int checks = 0;
  int errors = 0;

  sram_array_seq dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready_a), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a),
    .precharge(precharge_a), .wl_wr(wl_wr_a), .wl_rd(wl_rd_a),
    .wr_en(wr_en_a), .din(din_a), .sae(sae_a), .sa_out(sa_out[0])
  );

  sram_array_seq #(.ROWS(3), .COLS(8), .PRE_CYC(1), .WR_CYC(1), .RD_CYC(1), .SA_CYC(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready_b), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
    .precharge(precharge_b), .wl_wr(wl_wr_b), .wl_rd(wl_rd_b),
    .wr_en(wr_en_b), .din(din_b), .sae(sae_b), .sa_out(sa_out[1])
  );

  always_comb begin
    req_ready[0] = req_ready_a;  req_ready[1] = req_ready_b;
    rsp_valid[0] = rsp_valid_a;  rsp_valid[1] = rsp_valid_b;
    rsp_err[0]   = rsp_err_a;    rsp_err[1]   = rsp_err_b;
    rsp_rdata[0] = rsp_rdata_a;  rsp_rdata[1] = rsp_rdata_b;
    precharge[0] = precharge_a;  precharge[1] = precharge_b;
    wl_wr[0]     = wl_wr_a;      wl_wr[1]     = {1'b0, wl_wr_b};
    wl_rd[0]     = wl_rd_a;      wl_rd[1]     = {1'b0, wl_rd_b};
    wr_en[0]     = wr_en_a;      wr_en[1]     = wr_en_b;
    din[0]       = din_a;        din[1]       = din_b;
    sae[0]       = sae_a;        sae[1]       = sae_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Array-side invariants on both builds, every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        check("inv_onehot", 32'($onehot0(wl_wr[i] | wl_rd[i])), 32'd1);
        check("inv_pre_wl", 32'(precharge[i] && ((wl_wr[i] | wl_rd[i]) != 4'd0)), 32'd0);
        check("inv_wren", 32'(wr_en[i]), 32'(wl_wr[i] != 4'd0));
        if (!wr_en[i]) check("inv_din", 32'(din[i]), 32'd0);
      end
    end
  end

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!req_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) check("ready_wait", 32'(req_ready[i]), 32'd1);
  endtask

  // One access with cycle-by-cycle expectations derived from the phase widths.
  task automatic access(input int i, input bit we, input int addr, input logic [7:0] data, input bit hold);
    bit err;
    int pre, lat, sa_first;
    bit wl_on;
    logic [31:0] onehot;
    err      = (addr >= ROWS_C[i]);
    pre      = PRE_C[i];
    lat      = err ? 1 : (we ? pre + WR_C[i] + 1 : pre + RD_C[i] + SA_C[i] + 1);
    sa_first = lat - SA_C[i];
    onehot   = 32'd1 << addr;
    wait_ready(i);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr[1:0];
    req_wdata[i] = data;
    @(posedge clk); #1;
    if (!hold) req_valid[i] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      sa_out[i] = (k == lat - 1) ? data : ~data;
      @(negedge clk);
      wl_on = !err && (k > pre) && (k < lat);
      check("precharge", 32'(precharge[i]), 32'(!err && k <= pre));
      check("wl_wr", 32'(wl_wr[i]), (we && wl_on) ? onehot : 32'd0);
      check("wl_rd", 32'(wl_rd[i]), (!we && wl_on) ? onehot : 32'd0);
      check("wr_en", 32'(wr_en[i]), 32'(we && wl_on));
      check("din", 32'(din[i]), (we && wl_on) ? 32'(data) : 32'd0);
      check("sae", 32'(sae[i]), 32'(!we && wl_on && k >= sa_first));
      check("rsp_valid", 32'(rsp_valid[i]), 32'(k == lat));
      check("rsp_err", 32'(rsp_err[i]), 32'(k == lat && err));
      check("rsp_rdata", 32'(rsp_rdata[i]), (k == lat && !we && !err) ? 32'(data) : 32'd0);
      check("req_ready_busy", 32'(req_ready[i]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("req_ready_after", 32'(req_ready[i]), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid[i]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 2'd0;
      req_wdata[i] = 8'h00;
      sa_out[i]    = 8'h00;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
      check("rst_rdata", 32'(rsp_rdata[i]), 32'd0);
      check("rst_precharge", 32'(precharge[i]), 32'd0);
      check("rst_wl", 32'(wl_wr[i] | wl_rd[i]), 32'd0);
      check("rst_wr_en", 32'(wr_en[i]), 32'd0);
      check("rst_din", 32'(din[i]), 32'd0);
      check("rst_sae", 32'(sae[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Default build: single write and read of row 2.
    access(0, 1'b1, 2, 8'hA5, 1'b0);
    access(0, 1'b0, 2, 8'hA5, 1'b0);

    // req_valid held high across alternating accesses.
    access(0, 1'b1, 1, 8'h3C, 1'b1);
    access(0, 1'b0, 1, 8'h5A, 1'b1);
    access(0, 1'b1, 3, 8'hC3, 1'b1);
    access(0, 1'b0, 3, 8'h0F, 1'b1);
    req_valid[0] = 1'b0;

    // ROWS=3 fast build: out-of-range address, then short write/read.
    access(1, 1'b1, 3, 8'h77, 1'b0);
    access(1, 1'b0, 3, 8'h11, 1'b0);
    access(1, 1'b1, 1, 8'h96, 1'b0);
    access(1, 1'b0, 2, 8'hE7, 1'b0);
    access(1, 1'b0, 0, 8'h42, 1'b0);

    // Asynchronous reset in the middle of a write.
    wait_ready(0);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 2'd2;
    req_wdata[0] = 8'h3C;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_wl", 32'(wl_wr[0]), 32'h4);
    check("abort_pre_din", 32'(din[0]), 32'h3C);
    #2;
    rst = 1'b1;
    #1;
    check("abort_wl_wr", 32'(wl_wr[0]), 32'd0);
    check("abort_wr_en", 32'(wr_en[0]), 32'd0);
    check("abort_din", 32'(din[0]), 32'd0);
    check("abort_ready", 32'(req_ready[0]), 32'd1);
    check("abort_rsp", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
      check("abort_idle_ready", 32'(req_ready[0]), 32'd1);
    end

    access(0, 1'b0, 0, 8'h81, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
